// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (7-bit addr) turning SCL/SDA into register-file writes (wr_valid/wr_addr/wr_data) and reads (rd_addr/rd_data), pulling SDA via sda_oe, busy while addressed
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int PTR_W = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic [7:0] r_shift, w_shift_nxt, r_wr_data, w_wr_data_nxt, w_byte;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, r_wr_addr, w_wr_addr_nxt;
  logic r_sda_oe, w_sda_oe_nxt, r_wr_valid, w_wr_valid_nxt;
  logic r_busy, w_busy_nxt, r_first, w_first_nxt;
  logic w_scl, w_sda, w_start, w_stop, w_rise, w_fall, w_match;
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  assign w_start = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop = r_scl_d & w_scl & ~r_sda_d & w_sda;
  assign w_rise = ~r_scl_d & w_scl;
  assign w_fall = r_scl_d & ~w_scl;
  assign w_byte = {r_shift[6:0], w_sda};
  assign w_match = w_byte[7:1] == DEV_ADDR;
  assign sda_oe = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy = r_busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_ptr <= '0;
      r_sda_oe <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt <= w_cnt_nxt;
      r_ptr <= w_ptr_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy <= w_busy_nxt;
      r_first <= w_first_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) w_state_nxt = S_ADDR;
    else if (w_stop) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_ADDR: if (w_rise && r_cnt == 4'd7) w_state_nxt = w_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_fall && r_cnt == 4'd9) w_state_nxt = r_shift[0] ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE: if (w_rise && r_cnt == 4'd7) w_state_nxt = S_WR_ACK;
        S_WR_ACK: if (w_fall && r_cnt == 4'd9) w_state_nxt = S_WR_BYTE;
        S_RD_BYTE: if (w_fall && r_cnt == 4'd8) w_state_nxt = S_RD_ACK;
        S_RD_ACK: begin
          if (w_rise && r_cnt == 4'd8 && w_sda) w_state_nxt = S_IGNORE;
          else if (w_fall && r_cnt == 4'd9) w_state_nxt = S_RD_BYTE;
        end
        default: ;
      endcase
    end
  end
  // r_cnt counts SCL rises in a byte; 8 = byte done (ACK slot pending), 9 = ACK clock seen
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt = r_cnt;
    w_ptr_nxt = r_ptr;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt = r_busy;
    w_first_nxt = r_first;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    if (w_start) begin
      w_cnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
    end else if (w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: if (w_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_busy_nxt = w_match;
            w_first_nxt = 1'b1;
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_rise && r_cnt == 4'd8) w_cnt_nxt = 4'd9;
          if (w_fall && r_cnt == 4'd8) w_sda_oe_nxt = 1'b1;
          if (w_fall && r_cnt == 4'd9) begin
            w_cnt_nxt = '0;
            w_shift_nxt = rd_data;
            w_sda_oe_nxt = (r_state == S_ADDR_ACK) && r_shift[0] && !rd_data[7];
          end
        end
        S_WR_BYTE: if (w_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_first_nxt = 1'b0;
            w_ptr_nxt = r_first ? w_byte[PTR_W-1:0] : r_ptr + 1'b1;
            w_wr_valid_nxt = !r_first;
            w_wr_addr_nxt = r_first ? r_wr_addr : r_ptr;
            w_wr_data_nxt = r_first ? r_wr_data : w_byte;
          end
        end
        S_RD_BYTE: begin
          if (w_rise) w_cnt_nxt = r_cnt + 4'd1;
          if (w_fall && r_cnt == 4'd8) w_sda_oe_nxt = 1'b0;
          else if (w_fall && r_cnt != 4'd0) begin
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = !r_shift[6];
          end
        end
        S_RD_ACK: begin
          if (w_rise && r_cnt == 4'd8) begin
            w_cnt_nxt = 4'd9;
            w_ptr_nxt = r_ptr + 1'b1;
          end
          if (w_fall && r_cnt == 4'd9) begin
            w_cnt_nxt = '0;
            w_shift_nxt = rd_data;
            w_sda_oe_nxt = !rd_data[7];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master driving i2c_target_regs against a register-file model
module tb_i2c_target_regs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic sda_line, sda_oe, wr_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [7:0] regfile [16];
  logic [7:0] ref_mem [16];
  logic [3:0] ref_ptr = 4'd0;
  logic [11:0] wr_q [$];
  logic prev_wv = 1'b0, prev_oe = 1'b0, scl_q = 1'b1, oe_seen = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign sda_line = m_sda & ~sda_oe;
  assign rd_data = regfile[rd_addr];
  i2c_target_regs dut (
    .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy)
  );
  always @(posedge clk) scl_q <= m_scl;
  always @(negedge clk) begin
    if (wr_valid) begin
      regfile[wr_addr] = wr_data;
      wr_q.push_back({wr_addr, wr_data});
      total++;
      if (prev_wv) begin bad++; $display("FAIL wr_valid_width got=2+ clks exp=1 clk"); end
    end
    if (!reset && sda_oe !== prev_oe) begin
      total++;
      if (scl_q) begin bad++; $display("FAIL sda_oe_timing got=change with scl high exp=change with scl low"); end
    end
    if (sda_oe) oe_seen = 1'b1;
    prev_wv = wr_valid;
    prev_oe = sda_oe;
  end
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_start;
    m_sda = 1'b1; wt(5); m_scl = 1'b1; wt(5); m_sda = 1'b0; wt(5); m_scl = 1'b0; wt(5);
  endtask
  task automatic bus_stop;
    m_sda = 1'b0; wt(5); m_scl = 1'b1; wt(5); m_sda = 1'b1; wt(5);
  endtask
  task automatic do_bit(input logic b, output logic s);
    m_sda = b; wt(5); m_scl = 1'b1; wt(5); s = sda_line; wt(5); m_scl = 1'b0; wt(5);
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) do_bit(b[i], s);
    do_bit(1'b1, s);
    ack = ~s;
  endtask
  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin do_bit(1'b1, s); b[i] = s; end
    do_bit(~ack, s);
  endtask
  task automatic test_reset;
    reset = 1'b1; wt(4); reset = 1'b0; wt(2);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    total++; if (wr_data !== 8'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", rd_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask
  task automatic test_write_burst;
    logic [7:0] bytes [4] = '{8'h78, 8'h05, 8'hA1, 8'hB2};
    logic [11:0] exp [2] = '{{4'd5, 8'hA1}, {4'd6, 8'hB2}};
    logic a;
    wr_q.delete();
    bus_start;
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL wb_ack%0d got=%b exp=1", i, a); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wb_busy got=%b exp=1", busy); end
    bus_stop;
    wt(5);
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL wb_count got=%0d exp=2", wr_q.size()); end
    for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp[i]) begin bad++; $display("FAIL wb_entry%0d got=%h exp=%h", i, wr_q[i], exp[i]); end
    end
    total++; if (rd_addr !== 4'd7) begin bad++; $display("FAIL wb_ptr got=%h exp=7", rd_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wb_busy_end got=%b exp=0", busy); end
    ref_ptr = 4'd7;
  endtask
  task automatic test_read_rs;
    logic a;
    logic [7:0] d0, d1;
    for (int i = 0; i < 16; i++) begin regfile[i] = 8'h40 + 8'(i); ref_mem[i] = 8'h40 + 8'(i); end
    bus_start;
    write_byte(8'h78, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rd_ack_addr got=%b exp=1", a); end
    write_byte(8'h0F, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rd_ack_ptr got=%b exp=1", a); end
    bus_start;
    write_byte(8'h79, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rd_ack_raddr got=%b exp=1", a); end
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    bus_stop;
    wt(5);
    total++; if (d0 !== 8'h4F) begin bad++; $display("FAIL rd_byte0 got=%h exp=4f", d0); end
    total++; if (d1 !== 8'h40) begin bad++; $display("FAIL rd_byte1 got=%h exp=40", d1); end
    total++; if (rd_addr !== 4'd1) begin bad++; $display("FAIL rd_ptr got=%h exp=1", rd_addr); end
    ref_ptr = 4'd1;
  endtask
  task automatic test_mismatch;
    logic a;
    wr_q.delete();
    oe_seen = 1'b0;
    bus_start;
    write_byte(8'h7A, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL mm_ack_addr got=%b exp=0", a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mm_busy got=%b exp=0", busy); end
    write_byte(8'h55, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL mm_ack_data got=%b exp=0", a); end
    bus_stop;
    wt(5);
    total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL mm_oe_seen got=%b exp=0", oe_seen); end
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL mm_writes got=%0d exp=0", wr_q.size()); end
    total++; if (rd_addr !== ref_ptr) begin bad++; $display("FAIL mm_ptr got=%h exp=%h", rd_addr, ref_ptr); end
  endtask
  task automatic test_reset_mid_read;
    logic a, s;
    regfile[3] = 8'h00;
    ref_mem[3] = 8'h00;
    wr_q.delete();
    bus_start;
    write_byte(8'h78, a);
    write_byte(8'h03, a);
    bus_start;
    write_byte(8'h79, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rmr_ack got=%b exp=1", a); end
    for (int i = 0; i < 4; i++) begin
      do_bit(1'b1, s);
      total++; if (s !== 1'b0) begin bad++; $display("FAIL rmr_bit%0d got=%b exp=0", 7 - i, s); end
    end
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rmr_driving got=%b exp=1", sda_oe); end
    reset = 1'b1; wt(1);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rmr_oe_after_reset got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_busy got=%b exp=0", busy); end
    total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL rmr_ptr got=%h exp=0", rd_addr); end
    reset = 1'b0; wt(3);
    ref_ptr = 4'd0;
    bus_start;
    write_byte(8'h78, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rmr_w_ack0 got=%b exp=1", a); end
    write_byte(8'h02, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rmr_w_ack1 got=%b exp=1", a); end
    write_byte(8'h99, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rmr_w_ack2 got=%b exp=1", a); end
    bus_stop;
    wt(5);
    ref_mem[2] = 8'h99;
    ref_ptr = 4'd3;
    total++; if (wr_q.size() != 1 || wr_q[0] !== {4'd2, 8'h99}) begin bad++; $display("FAIL rmr_write got=%0d entries exp=1 entry 299", wr_q.size()); end
    total++; if (rd_addr !== ref_ptr) begin bad++; $display("FAIL rmr_ptr_end got=%h exp=%h", rd_addr, ref_ptr); end
  endtask
  task automatic test_stop_mid_byte;
    logic a, s;
    logic [7:0] d;
    wr_q.delete();
    bus_start;
    write_byte(8'h78, a);
    for (int i = 0; i < 4; i++) do_bit(1'b0, s);
    bus_stop;
    wt(5);
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL smb_writes got=%0d exp=0", wr_q.size()); end
    total++; if (rd_addr !== ref_ptr) begin bad++; $display("FAIL smb_ptr got=%h exp=%h", rd_addr, ref_ptr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL smb_busy got=%b exp=0", busy); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL smb_oe got=%b exp=0", sda_oe); end
    bus_start;
    write_byte(8'h79, a);
    read_byte(1'b0, d);
    bus_stop;
    wt(5);
    total++; if (d !== ref_mem[ref_ptr]) begin bad++; $display("FAIL smb_read got=%h exp=%h", d, ref_mem[ref_ptr]); end
    ref_ptr++;
    total++; if (rd_addr !== ref_ptr) begin bad++; $display("FAIL smb_ptr_end got=%h exp=%h", rd_addr, ref_ptr); end
  endtask
  task automatic test_random;
    logic a;
    logic [7:0] b, d;
    logic [11:0] exp_q [$];
    int n, kind;
    for (int i = 0; i < 16; i++) begin b = 8'($urandom); regfile[i] = b; ref_mem[i] = b; end
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      wr_q.delete();
      exp_q.delete();
      bus_start;
      if (kind != 2) begin
        write_byte(8'h78, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL rnd_ack_addr t=%0d got=%b exp=1", t, a); end
        b = 8'($urandom);
        write_byte(b, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL rnd_ack_ptr t=%0d got=%b exp=1", t, a); end
        ref_ptr = b[3:0];
      end
      if (kind == 0) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          write_byte(d, a);
          total++; if (a !== 1'b1) begin bad++; $display("FAIL rnd_ack_data t=%0d got=%b exp=1", t, a); end
          exp_q.push_back({ref_ptr, d});
          ref_mem[ref_ptr] = d;
          ref_ptr++;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rnd_busy t=%0d got=%b exp=1", t, busy); end
      end else begin
        if (kind == 1) bus_start;
        write_byte(8'h79, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL rnd_ack_raddr t=%0d got=%b exp=1", t, a); end
        for (int k = 0; k < n; k++) begin
          read_byte(k != n - 1, d);
          total++; if (d !== ref_mem[ref_ptr]) begin bad++; $display("FAIL rnd_read t=%0d got=%h exp=%h", t, d, ref_mem[ref_ptr]); end
          ref_ptr++;
        end
      end
      bus_stop;
      wt(5);
      total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_wcount t=%0d got=%0d exp=%0d", t, wr_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
        total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd_write t=%0d got=%h exp=%h", t, wr_q[k], exp_q[k]); end
      end
      total++; if (rd_addr !== ref_ptr) begin bad++; $display("FAIL rnd_ptr t=%0d got=%h exp=%h", t, rd_addr, ref_ptr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy_end t=%0d got=%b exp=0", t, busy); end
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin regfile[i] = 8'h00; ref_mem[i] = 8'h00; end
    test_reset;
    test_write_burst;
    test_read_rs;
    test_mismatch;
    test_reset_mid_read;
    test_stop_mid_byte;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) that decodes the bus driven by the bit-banged SCL/SDA PIO master.
- Gives the MCU's I2C traffic a hardware end-point for register access inside the FPGA.
- Supports 7-bit addressing, standard/fast mode, and a byte-wide auto-incrementing register pointer.
- Exposes a simple local register-file handshake for writes and reads.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit target address matched after START.
- PTR_W, 4, register pointer width; pointer space is 2^PTR_W bytes.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2).

Ports:
- clk  in  1  system clock, at least 20x the SCL rate.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- wr_valid  out  1  one-clk pulse; the write byte is in wr_addr/wr_data.
- wr_addr  out  PTR_W  register index for the write.
- wr_data  out  8  write byte.
- rd_addr  out  PTR_W  register index currently requested; always equals the pointer.
- rd_data  in  8  read byte from the register file; must be valid 1 clk after rd_addr changes.
- busy  out  1  high from address match until STOP or a non-matching address.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0 (pointer=0), busy=0, state=IDLE, synchronizers=1.
- Reset mid-transfer: the bus is released immediately (next clk). The target stays idle until a fresh START.
- Input path: scl_in and sda_in pass through SYNC_STAGES flops. Edges are detected on the synchronized values.
- START: synced SDA falls while SCL is high.
- STOP: synced SDA rises while SCL is high.
- Data sampling: data bits are sampled on synced SCL rising edges, MSB first.
- Data driving: sda_oe changes only on the clk following a synced SCL falling edge. It never changes while SCL is high.
- START or repeated START in any state: go to ADDR, clear the bit counter, sda_oe=0. The pointer is retained.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. The pointer is retained.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match: ADDR_ACK, busy=1.
    - Mismatch: IGNORE, sda_oe stays 0 until STOP or START.
  - ADDR_ACK: drive ACK (sda_oe=1) for the 9th SCL pulse.
    - R/W=0: go to WR_BYTE.
    - R/W=1: go to RD_BYTE and load the shift register from rd_data.
  - WR_BYTE: shift 8 bits.
    - First byte after the address: loads the pointer (low PTR_W bits; upper bits are ignored), no wr_valid.
    - Each later byte: wr_valid pulse with wr_addr=pointer, wr_data=byte, then pointer increments.
    - wr_valid fires within 2 clks of the synced 8th SCL rise. Then go to WR_ACK.
  - WR_ACK: ACK every byte, then return to WR_BYTE.
  - RD_BYTE: drive sda_oe=~bit, MSB first, changing after each SCL fall. After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on the SCL rise.
    - ACK (SDA=0): pointer increments, shift register reloads from rd_data at the SCL fall, go to RD_BYTE.
    - NACK: IGNORE. The pointer still increments.
- Pointer wrap: mod 2^PTR_W (4'hF + 1 -> 4'h0), for both reads and writes.
- Simultaneous START/STOP with a data edge: START/STOP takes priority over bit processing.
- Glitch rule: an SCL pulse shorter than SYNC_STAGES clks may be missed. This is not an error condition.

Test Plan:
- Write burst: START, 0x78 (0x3C,W), 0x05, 0xA1, 0xB2, STOP -> ACK on all 4 bytes; wr_valid pulses (addr 5, 0xA1) then (addr 6, 0xB2); pointer=7, busy=0 after STOP.
- Read with repeated START: START, 0x78, 0x0F, Sr, 0x79, read 2 bytes (ACK, NACK), STOP, rd_data = 0x40+rd_addr -> SDA carries 0x4F then 0x40 (pointer wraps 0xF->0x0); final pointer 0x1.
- Address mismatch: START, 0x7A, 0x55, STOP -> sda_oe never asserted, no wr_valid, busy stays 0.
- Reset mid-read: assert reset while driving bit 3 of a read byte with SDA held low -> sda_oe=0 next clk, state IDLE, pointer 0; a subsequent full write transaction succeeds.
- STOP mid-byte: START, 0x78, 4 bits of 0x05, STOP -> no pointer load, no wr_valid, IDLE, sda_oe=0.
- Timing check: SCL at clk/20 -> sda_oe changes only while synced SCL is low, and every wr_valid is exactly 1 clk wide.
